// File: rtl/traffic_pkg.sv
// Shared phase encoding, default timing and lamp bundle for the intersection scheduler.
package traffic_pkg;

  typedef enum logic [2:0] {
    A_GO      = 3'd0,
    A_SLOW    = 3'd1,
    CLR_AB    = 3'd2,
    B_GO      = 3'd3,
    B_SLOW    = 3'd4,
    CLR_BA    = 3'd5,
    NIGHT_ON  = 3'd6,
    NIGHT_OFF = 3'd7
  } phase_e;

  localparam int DEF_T_GREEN     = 8;
  localparam int DEF_T_GREEN_MIN = 3;
  localparam int DEF_T_YELLOW    = 2;
  localparam int DEF_T_ALLRED    = 1;
  localparam int DEF_T_WALK      = 4;
  localparam int DEF_CNT_W       = 4;

  typedef struct packed {
    logic green;
    logic yellow;
    logic red;
  } lamp_t;

  function automatic logic isNight(input phase_e p);
    return (p == NIGHT_ON) || (p == NIGHT_OFF);
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Tick-driven down counter; reload takes priority and the count parks at zero.
module phase_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             tick_i,
  output logic             zero_o,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (load_i) begin
      count_q <= load_val_i;
    end else if (tick_i && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero_o  = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Two-road phase sequencer: timed day cycle with pedestrian truncation and walk lamps,
// blinking yellow at night. Lamps are a Moore decode of the phase register.
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int T_GREEN     = DEF_T_GREEN,
  parameter int T_GREEN_MIN = DEF_T_GREEN_MIN,
  parameter int T_YELLOW    = DEF_T_YELLOW,
  parameter int T_ALLRED    = DEF_T_ALLRED,
  parameter int T_WALK      = DEF_T_WALK,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       modo,
  input  logic       ped_req_a,
  input  logic       ped_req_b,
  output logic       A_green,
  output logic       A_yellow,
  output logic       A_red,
  output logic       B_green,
  output logic       B_yellow,
  output logic       B_red,
  output logic       walk_a,
  output logic       walk_b,
  output logic [2:0] phase
);

  phase_e           state_q, state_d;
  logic             reqA_q, reqA_d, reqB_q, reqB_d;
  logic             walkA_q, walkA_d, walkB_q, walkB_d;
  logic             timerLoad, timerZero;
  logic [CNT_W-1:0] timerLoadVal, timerCount, elapsed;
  logic             expire, minDone, nightNow, enterAGo, enterBGo;
  lamp_t            lampA, lampB;

  function automatic logic [CNT_W-1:0] durMinusOne(input phase_e p);
    case (p)
      A_GO, B_GO:          return CNT_W'(T_GREEN - 1);
      A_SLOW, B_SLOW:      return CNT_W'(T_YELLOW - 1);
      NIGHT_ON, NIGHT_OFF: return '0;
      default:             return CNT_W'(T_ALLRED - 1);
    endcase
  endfunction

  // Every state change reloads the timer, so each phase starts with a fresh duration.
  assign timerLoad    = reset || (state_d != state_q);
  assign timerLoadVal = reset ? CNT_W'(T_ALLRED - 1) : durMinusOne(state_d);

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk_i      (clk),
    .load_i     (timerLoad),
    .load_val_i (timerLoadVal),
    .tick_i     (tick),
    .zero_o     (timerZero),
    .count_o    (timerCount)
  );

  assign expire  = tick && timerZero;
  assign elapsed = CNT_W'(T_GREEN - 1) - timerCount;
  assign minDone = (elapsed >= CNT_W'(T_GREEN_MIN));

  always_comb begin
    state_d = state_q;
    case (state_q)
      A_GO:      if (tick && (modo || timerZero || (reqA_q && minDone))) state_d = A_SLOW;
      A_SLOW:    if (expire) state_d = CLR_AB;
      CLR_AB:    if (expire) state_d = modo ? NIGHT_ON : B_GO;
      B_GO:      if (tick && (modo || timerZero || (reqB_q && minDone))) state_d = B_SLOW;
      B_SLOW:    if (expire) state_d = CLR_BA;
      CLR_BA:    if (expire) state_d = modo ? NIGHT_ON : A_GO;
      NIGHT_ON:  if (tick) state_d = modo ? NIGHT_OFF : CLR_BA;
      NIGHT_OFF: if (tick) state_d = modo ? NIGHT_ON : CLR_BA;
      default:   state_d = CLR_BA;
    endcase
  end

  // A request is served at entry of the opposite green; a press in that same cycle re-arms it.
  assign nightNow = isNight(state_q) || isNight(state_d);
  assign enterAGo = (state_d == A_GO) && (state_q != A_GO);
  assign enterBGo = (state_d == B_GO) && (state_q != B_GO);
  assign reqA_d   = !nightNow && (ped_req_a || (reqA_q && !enterBGo));
  assign reqB_d   = !nightNow && (ped_req_b || (reqB_q && !enterAGo));
  assign walkA_d  = !nightNow && (enterBGo ? reqA_q : walkA_q);
  assign walkB_d  = !nightNow && (enterAGo ? reqB_q : walkB_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLR_BA;
      reqA_q  <= 1'b0;
      reqB_q  <= 1'b0;
      walkA_q <= 1'b0;
      walkB_q <= 1'b0;
    end else begin
      state_q <= state_d;
      reqA_q  <= reqA_d;
      reqB_q  <= reqB_d;
      walkA_q <= walkA_d;
      walkB_q <= walkB_d;
    end
  end

  always_comb begin
    lampA = '0;
    lampB = '0;
    case (state_q)
      A_GO:           begin lampA.green  = 1'b1; lampB.red    = 1'b1; end
      A_SLOW:         begin lampA.yellow = 1'b1; lampB.red    = 1'b1; end
      B_GO:           begin lampA.red    = 1'b1; lampB.green  = 1'b1; end
      B_SLOW:         begin lampA.red    = 1'b1; lampB.yellow = 1'b1; end
      NIGHT_ON:       begin lampA.yellow = 1'b1; lampB.yellow = 1'b1; end
      NIGHT_OFF:      begin lampA = '0; lampB = '0; end
      default:        begin lampA.red    = 1'b1; lampB.red    = 1'b1; end
    endcase
  end

  assign A_green  = lampA.green;
  assign A_yellow = lampA.yellow;
  assign A_red    = lampA.red;
  assign B_green  = lampB.green;
  assign B_yellow = lampB.yellow;
  assign B_red    = lampB.red;
  // Walk for road A runs during B's green (A is red), timed from B_GO entry.
  assign walk_a   = walkA_q && (state_q == B_GO) && (elapsed < CNT_W'(T_WALK));
  assign walk_b   = walkB_q && (state_q == A_GO) && (elapsed < CNT_W'(T_WALK));
  assign phase    = state_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler with default timing, plus a short random
// sweep checking lamp safety rules every cycle.
module tb_traffic_phase_scheduler;
  import traffic_pkg::*;

  logic       clk = 1'b0;
  logic       reset, tick, modo, ped_req_a, ped_req_b;
  logic       A_green, A_yellow, A_red, B_green, B_yellow, B_red;
  logic       walk_a, walk_b;
  logic [2:0] phase;

  int testCount = 0;
  int failCount = 0;

  traffic_phase_scheduler dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .modo      (modo),
    .ped_req_a (ped_req_a),
    .ped_req_b (ped_req_b),
    .A_green   (A_green),
    .A_yellow  (A_yellow),
    .A_red     (A_red),
    .B_green   (B_green),
    .B_yellow  (B_yellow),
    .B_red     (B_red),
    .walk_a    (walk_a),
    .walk_b    (walk_b),
    .phase     (phase)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] lampsFor(input phase_e p);
    case (p)
      A_GO:     return 6'b100_001;
      A_SLOW:   return 6'b010_001;
      B_GO:     return 6'b001_100;
      B_SLOW:   return 6'b001_010;
      NIGHT_ON: return 6'b010_010;
      NIGHT_OFF:return 6'b000_000;
      default:  return 6'b001_001;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic doTick();
    tick = 1'b1;
    stepClock();
    tick = 1'b0;
    repeat (3) stepClock();
  endtask

  task automatic applyStimulus(input logic m, input logic pa, input logic pb);
    modo      = m;
    ped_req_a = pa;
    ped_req_b = pb;
  endtask

  task automatic pulsePed(input logic pa, input logic pb);
    applyStimulus(modo, pa, pb);
    stepClock();
    applyStimulus(modo, 1'b0, 1'b0);
  endtask

  // Check phase, lamps and walks before each of n ticks; the phase must persist for all n.
  task automatic expectRun(input string tag, input phase_e p, input int n,
                           input logic wa, input logic wb);
    for (int i = 0; i < n; i++) begin
      checkOutput({tag, "/phase"}, 32'(phase), 32'(p));
      checkOutput({tag, "/lamps"},
                  32'({A_green, A_yellow, A_red, B_green, B_yellow, B_red}), 32'(lampsFor(p)));
      checkOutput({tag, "/walk"}, 32'({walk_a, walk_b}), 32'({wa, wb}));
      doTick();
    end
  endtask

  initial begin
    logic [2:0] la, lb;
    logic       conflict;

    applyStimulus(1'b0, 1'b0, 1'b0);
    tick  = 1'b0;
    reset = 1'b1;
    repeat (2) stepClock();
    reset = 1'b0;
    checkOutput("reset/phase", 32'(phase), 32'(CLR_BA));
    checkOutput("reset/lamps", 32'({A_green, A_yellow, A_red, B_green, B_yellow, B_red}), 32'h09);
    checkOutput("reset/walk", 32'({walk_a, walk_b}), 32'h0);

    $display("[TB] 1: nominal day cycle");
    expectRun("t1", CLR_BA, 1, 0, 0);
    expectRun("t1", A_GO,   8, 0, 0);
    expectRun("t1", A_SLOW, 2, 0, 0);
    expectRun("t1", CLR_AB, 1, 0, 0);
    expectRun("t1", B_GO,   8, 0, 0);
    expectRun("t1", B_SLOW, 2, 0, 0);
    expectRun("t1", CLR_BA, 1, 0, 0);

    $display("[TB] 2: early request truncates A green");
    expectRun("t2", A_GO,   1, 0, 0);
    pulsePed(1'b1, 1'b0);
    expectRun("t2", A_GO,   3, 0, 0);
    expectRun("t2", A_SLOW, 2, 0, 0);
    expectRun("t2", CLR_AB, 1, 0, 0);
    expectRun("t2w", B_GO,  4, 1, 0);
    expectRun("t2", B_GO,   4, 0, 0);
    expectRun("t2", B_SLOW, 2, 0, 0);
    expectRun("t2", CLR_BA, 1, 0, 0);
    expectRun("t2clr", A_GO, 8, 0, 0);
    expectRun("t2", A_SLOW, 2, 0, 0);
    expectRun("t2", CLR_AB, 1, 0, 0);
    expectRun("t2clr", B_GO, 8, 0, 0);
    expectRun("t2", B_SLOW, 2, 0, 0);
    expectRun("t2", CLR_BA, 1, 0, 0);

    $display("[TB] 3: late request and re-press during walk");
    expectRun("t3", A_GO,   6, 0, 0);
    pulsePed(1'b1, 1'b0);
    expectRun("t3", A_GO,   1, 0, 0);
    expectRun("t3", A_SLOW, 2, 0, 0);
    expectRun("t3", CLR_AB, 1, 0, 0);
    expectRun("t3w", B_GO,  2, 1, 0);
    pulsePed(1'b1, 1'b0);
    expectRun("t3w", B_GO,  2, 1, 0);
    expectRun("t3", B_GO,   4, 0, 0);
    expectRun("t3", B_SLOW, 2, 0, 0);
    expectRun("t3", CLR_BA, 1, 0, 0);
    expectRun("t3re", A_GO, 4, 0, 0);
    expectRun("t3", A_SLOW, 2, 0, 0);
    expectRun("t3", CLR_AB, 1, 0, 0);
    expectRun("t3rew", B_GO, 4, 1, 0);
    expectRun("t3", B_GO,   4, 0, 0);
    expectRun("t3", B_SLOW, 2, 0, 0);
    expectRun("t3", CLR_BA, 1, 0, 0);

    $display("[TB] 4: night entry from A green");
    expectRun("t4", A_GO,   2, 0, 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    expectRun("t4", A_GO,   1, 0, 0);
    expectRun("t4", A_SLOW, 2, 0, 0);
    expectRun("t4", CLR_AB, 1, 0, 0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    expectRun("t4n", NIGHT_ON,  1, 0, 0);
    expectRun("t4n", NIGHT_OFF, 1, 0, 0);
    expectRun("t4n", NIGHT_ON,  1, 0, 0);

    $display("[TB] 5: night exit and modo glitch between ticks");
    applyStimulus(1'b0, 1'b0, 1'b0);
    expectRun("t5", NIGHT_OFF, 1, 0, 0);
    expectRun("t5", CLR_BA, 1, 0, 0);
    expectRun("t5", A_GO,   3, 0, 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    stepClock();
    applyStimulus(1'b0, 1'b0, 1'b0);
    expectRun("t5g", A_GO,  5, 0, 0);
    expectRun("t5", A_SLOW, 2, 0, 0);
    expectRun("t5", CLR_AB, 1, 0, 0);
    expectRun("t5ign", B_GO, 8, 0, 0);
    expectRun("t5", B_SLOW, 2, 0, 0);
    expectRun("t5", CLR_BA, 1, 0, 0);
    expectRun("t5", A_GO,   8, 0, 0);
    expectRun("t5", A_SLOW, 2, 0, 0);
    expectRun("t5", CLR_AB, 1, 0, 0);
    expectRun("t5", B_GO,   3, 0, 0);

    $display("[TB] 6: reset mid B green with tick and request");
    reset = 1'b1;
    tick  = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1);
    stepClock();
    reset = 1'b0;
    tick  = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("t6/phase", 32'(phase), 32'(CLR_BA));
    checkOutput("t6/lamps", 32'({A_green, A_yellow, A_red, B_green, B_yellow, B_red}), 32'h09);
    checkOutput("t6/walk", 32'({walk_a, walk_b}), 32'h0);
    repeat (2) stepClock();
    expectRun("t6", CLR_BA, 1, 0, 0);
    expectRun("t6latch", A_GO, 8, 0, 0);
    expectRun("t6", A_SLOW, 2, 0, 0);
    expectRun("t6", CLR_AB, 1, 0, 0);
    expectRun("t6", B_GO,   1, 0, 0);
    pulsePed(1'b0, 1'b1);
    expectRun("t6", B_GO,   3, 0, 0);
    expectRun("t6", B_SLOW, 2, 0, 0);
    expectRun("t6", CLR_BA, 1, 0, 0);
    expectRun("t6w", A_GO,  4, 0, 1);
    expectRun("t6", A_GO,   4, 0, 0);

    $display("[TB] 7: random sweep of safety rules");
    for (int i = 0; i < 3000; i++) begin
      tick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 199) == 0) modo = ~modo;
      ped_req_a = ($urandom_range(0, 9) == 0);
      ped_req_b = ($urandom_range(0, 9) == 0);
      stepClock();
      la = {A_green, A_yellow, A_red};
      lb = {B_green, B_yellow, B_red};
      conflict = (A_green || A_yellow) && (B_green || B_yellow) &&
                 !(phase == NIGHT_ON && la == 3'b010 && lb == 3'b010);
      checkOutput("t7/oneHot", 32'(($countones(la) > 1) || ($countones(lb) > 1)), 32'h0);
      checkOutput("t7/dayLit", 32'((phase != NIGHT_OFF) &&
                  (($countones(la) != 1) || ($countones(lb) != 1))), 32'h0);
      checkOutput("t7/conflict", 32'(conflict), 32'h0);
      checkOutput("t7/walkRed", 32'((walk_a && !A_red) || (walk_b && !B_red)), 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
